// File: rtl/bp_pkg.sv
// Purpose: shared types and helpers for the branch history table predictor.
// Contents: FSM state enum (INIT sweep / RUN) and the weak-taken /
//           weak-not-taken counter reset values as functions of CNT_W.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Weakly-taken value: MSB set, all lower bits clear.
  function automatic int weak_taken(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken value: MSB clear, all lower bits set.
  function automatic int weak_not_taken(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Purpose: next-state of a CNT_W-bit saturating direction counter.
// Ports: ctr_i current count, taken_i resolved outcome, ctr_o next count.
// Combinational, zero latency; saturates at 0 and 2^CNT_W-1.
module sat_counter_update #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != {CNT_W{1'b1}}) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Purpose: direct-mapped tagged branch history table with saturating counters,
//          combinational prediction/target, resolved-branch training and perf counters.
// Ports: clk/rst_n (sync, active-low); lookup_* -> predict/target (combinational);
//        update_* trains the table from MEM; ready once the init sweep finishes;
//        branch_count / mispredict_count saturating performance counters.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  input  logic [31:0]       lookup_offset,
  output logic              predict,
  output logic [31:0]       target,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic              update_mispredict,
  output logic              ready,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CTR_WNT = CNT_W'(weak_not_taken(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] ctr;
  } entry_t;

  // Single memory array, no reset: contents are established by the INIT sweep.
  entry_t mem_q [ENTRIES];

  state_e            state_q;
  logic              ready_q;
  logic [IDX_W-1:0]  sweep_q;
  logic [PERF_W-1:0] branch_q;
  logic [PERF_W-1:0] mispred_q;

  // Address decode
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Only the index/tag bit ranges of the PCs are meaningful here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, update_pc};

  // Lookup path: asynchronous read, no bypass from a same-cycle update.
  entry_t lk_ent;
  assign lk_ent = mem_q[lk_idx];
  assign target = lookup_pc + lookup_offset;
  // Gate with rst_n so ready/predict drop as soon as reset is asserted.
  assign ready   = ready_q & rst_n;
  assign predict = ready && lookup_valid && lk_ent.valid &&
                   (lk_ent.tag == lk_tag) && lk_ent.ctr[CNT_W-1];

  // Update path
  entry_t           up_ent;
  logic             up_hit;
  logic [CNT_W-1:0] ctr_next;
  assign up_ent = mem_q[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  sat_counter_update #(.CNT_W(CNT_W)) u_sat (
    .ctr_i   (up_ent.ctr),
    .taken_i (update_taken),
    .ctr_o   (ctr_next)
  );

  logic             run_upd;
  logic             wr_en_d;
  logic [IDX_W-1:0] wr_idx_d;
  entry_t           wr_dat_d;
  assign run_upd = (state_q == RUN) && update_valid;

  always_comb begin
    wr_en_d  = 1'b0;
    wr_idx_d = up_idx;
    wr_dat_d = '0;
    if (state_q == INIT) begin
      wr_en_d        = 1'b1;
      wr_idx_d       = sweep_q;
      wr_dat_d.valid = 1'b0;
      wr_dat_d.tag   = '0;
      wr_dat_d.ctr   = CTR_WNT;
    end else if (update_valid) begin
      wr_en_d        = 1'b1;
      wr_dat_d.valid = 1'b1;
      wr_dat_d.tag   = up_tag;
      if (up_hit)            wr_dat_d.ctr = ctr_next;
      else if (update_taken) wr_dat_d.ctr = CTR_WT;
      else                   wr_dat_d.ctr = CTR_WNT;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_idx_d] <= wr_dat_d;
  end

  // Sweep FSM and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      ready_q   <= 1'b0;
      sweep_q   <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          if (run_upd && !(&branch_q)) branch_q <= branch_q + 1'b1;
          if (run_upd && update_mispredict && !(&mispred_q))
            mispred_q <= mispred_q + 1'b1;
        end
      endcase
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] lookup_offset;
  logic        predict;
  logic [31:0] target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_mispredict;
  logic        ready;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predictor_bht #(
    .ENTRIES(16), .TAG_W(8), .CNT_W(2), .PERF_W(32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .lookup_offset     (lookup_offset),
    .predict           (predict),
    .target            (target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .ready             (ready),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic m);
    update_pc         = pc;
    update_taken      = t;
    update_mispredict = m;
    update_valid      = 1'b1;
    @(posedge clk);
    #1;
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] off);
    lookup_valid  = 1'b1;
    lookup_pc     = pc;
    lookup_offset = off;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h80; lookup_offset = 32'h4;
    update_valid = 1'b0; update_pc = 32'h0; update_taken = 1'b0; update_mispredict = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_predict", {31'b0, predict}, 32'd0);
    chk("rst_target", target, 32'h84);
    @(posedge clk);
    #1;
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_mcnt", mispredict_count, 32'd0);

    // Release reset; updates with mispredict are driven through the whole sweep.
    rst_n = 1'b1;
    update_valid = 1'b1; update_mispredict = 1'b1; update_pc = 32'h80; update_taken = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 16) begin
        update_valid = 1'b0;
        update_mispredict = 1'b0;
      end
      #1;
      chk($sformatf("sweep_ready_%0d", i), {31'b0, ready}, {31'b0, (i == 16)});
      if (i < 16) chk($sformatf("sweep_predict_%0d", i), {31'b0, predict}, 32'd0);
    end
    chk("init_bcnt", branch_count, 32'd0);
    chk("init_mcnt", mispredict_count, 32'd0);
    look(32'h80, 32'h0);
    chk("init_no_alloc", {31'b0, predict}, 32'd0);

    // Perf counters: 3 updates, 1 mispredict, then a stray mispredict without valid.
    upd(32'h104, 1'b1, 1'b0);
    upd(32'h108, 1'b0, 1'b1);
    upd(32'h10C, 1'b1, 1'b0);
    update_mispredict = 1'b1;
    @(posedge clk);
    #1;
    update_mispredict = 1'b0;
    chk("perf_bcnt", branch_count, 32'd3);
    chk("perf_mcnt", mispredict_count, 32'd1);

    // Allocate 0x40 weakly taken; target wraps for negative offsets.
    upd(32'h40, 1'b1, 1'b0);
    look(32'h40, 32'h10);
    chk("alloc_predict", {31'b0, predict}, 32'd1);
    chk("target_pos", target, 32'h50);
    look(32'h40, 32'hFFFF_FFF0);
    chk("target_neg", target, 32'h30);

    // Saturate high, then walk down through weak-taken to weak-not-taken.
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 1'b0);
    upd(32'h40, 1'b0, 1'b0);
    look(32'h40, 32'h0);
    chk("hyst_nt1", {31'b0, predict}, 32'd1);
    upd(32'h40, 1'b0, 1'b0);
    look(32'h40, 32'h0);
    chk("hyst_nt2", {31'b0, predict}, 32'd0);

    // Tag aliasing and eviction at index 0.
    upd(32'h40, 1'b1, 1'b0);
    look(32'h40, 32'h0);
    chk("retrain_40", {31'b0, predict}, 32'd1);
    look(32'h440, 32'h0);
    chk("alias_miss", {31'b0, predict}, 32'd0);
    upd(32'h440, 1'b0, 1'b0);
    look(32'h40, 32'h0);
    chk("evicted_40", {31'b0, predict}, 32'd0);
    look(32'h440, 32'h0);
    chk("alloc_wnt", {31'b0, predict}, 32'd0);

    // Same-cycle lookup and update: no bypass.
    look(32'h80, 32'h0);
    update_pc = 32'h80; update_taken = 1'b1; update_valid = 1'b1;
    #1;
    chk("same_cyc_before", {31'b0, predict}, 32'd0);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    #1;
    chk("same_cyc_after", {31'b0, predict}, 32'd1);
    lookup_valid = 1'b0;
    #1;
    chk("lookup_invalid", {31'b0, predict}, 32'd0);

    // Lower saturation at 0 on index 4.
    upd(32'h90, 1'b0, 1'b0);
    upd(32'h90, 1'b0, 1'b0);
    upd(32'h90, 1'b0, 1'b0);
    upd(32'h90, 1'b1, 1'b0);
    look(32'h90, 32'h0);
    chk("sat_low_1", {31'b0, predict}, 32'd0);
    upd(32'h90, 1'b1, 1'b0);
    look(32'h90, 32'h0);
    chk("sat_low_2", {31'b0, predict}, 32'd1);

    // 3 perf + 7 at 0x40 + 1 at 0x440 + 1 at 0x80 + 5 at 0x90
    chk("total_bcnt", branch_count, 32'd17);
    chk("total_mcnt", mispredict_count, 32'd1);

    // Reset pulse in RUN restarts the sweep and clears counters.
    look(32'h90, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_run_ready", {31'b0, ready}, 32'd0);
    chk("rst_run_predict", {31'b0, predict}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst2_bcnt", branch_count, 32'd0);
    chk("rst2_mcnt", mispredict_count, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #2;
      if (i >= 15) chk($sformatf("resweep_ready_%0d", i), {31'b0, ready}, {31'b0, (i == 16)});
    end
    chk("resweep_cleared", {31'b0, predict}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
